// File: rtl/fetch_pc_if.sv
// Fetch-stage bus: hazard/redirect controls in, memory address and IF/ID out.
// The slave side is the fetch unit; the master side is its environment.
interface fetch_pc_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [31:0]      instr_in;
  logic [31:0]      pc_out;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_pc4;
  logic             ifid_valid;
  logic             halted;
  logic             fetch_err;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output stall, redirect, redirect_pc, instr_in,
    input  pc_out, ifid_instr, ifid_pc4, ifid_valid,
    input  halted, fetch_err, fetch_count
  );

  modport slave (
    input  stall, redirect, redirect_pc, instr_in,
    output pc_out, ifid_instr, ifid_pc4, ifid_valid,
    output halted, fetch_err, fetch_count
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, loads IF/ID,
// handles stall, redirect, HALT word and fetch errors.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 400,
  parameter logic [31:0] HALT_WORD = 32'hFC00_0000,
  parameter int          CNT_W     = 16
) (
  input logic       clk,
  input logic       rst_n,
  fetch_pc_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  state_t           state, state_n;
  logic [31:0]      pc, pc_n;
  logic [31:0]      instr_q, instr_n;
  logic [31:0]      pc4_q, pc4_n;
  logic             valid_q, valid_n;
  logic             halt_q, halt_n;
  logic             err_q, err_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic [31:0] pc4;
  logic        redir_ok, redir_bad;
  logic        hold, oob, fetch;
  logic        is_halt;

  assign pc4 = pc + 32'd4;

  assign redir_ok = bus.redirect
                 && (bus.redirect_pc[1:0] == 2'b00)
                 && (bus.redirect_pc <= LAST_PC);
  assign redir_bad = bus.redirect && !redir_ok;

  // Exclusive decode of redirect > stall > normal
  assign hold  = !bus.redirect && bus.stall;
  assign oob   = !bus.redirect && !bus.stall
              && (pc > LAST_PC);
  assign fetch = !bus.redirect && !bus.stall
              && (pc <= LAST_PC);

  assign is_halt = (bus.instr_in == HALT_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      instr_q <= instr_n;
      pc4_q   <= pc4_n;
      valid_q <= valid_n;
      halt_q  <= halt_n;
      err_q   <= err_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr_q;
    pc4_n   = pc4_q;
    valid_n = valid_q;
    halt_n  = halt_q;
    err_n   = err_q;
    cnt_n   = cnt_q;
    unique case (state)
      IDLE: state_n = RUN;
      RUN: begin
        unique case (1'b1)
          redir_ok: begin
            pc_n    = bus.redirect_pc;
            instr_n = '0;
            pc4_n   = '0;
            valid_n = 1'b0;
          end
          redir_bad: begin
            state_n = HALT;
            halt_n  = 1'b1;
            err_n   = 1'b1;
            valid_n = 1'b0;
          end
          hold: ;
          oob: begin
            state_n = HALT;
            halt_n  = 1'b1;
            err_n   = 1'b1;
            valid_n = 1'b0;
          end
          fetch: begin
            instr_n = bus.instr_in;
            pc4_n   = pc4;
            valid_n = 1'b1;
            cnt_n   = (&cnt_q) ? cnt_q
                    : cnt_q + 1'b1;
            // HALT word is delivered, but PC parks on it
            if (is_halt) begin
              state_n = HALT;
              halt_n  = 1'b1;
            end else begin
              pc_n = pc4;
            end
          end
          default: ;
        endcase
      end
      HALT: valid_n = 1'b0;
      default: state_n = IDLE;
    endcase
  end

  assign bus.pc_out      = pc;
  assign bus.ifid_instr  = instr_q;
  assign bus.ifid_pc4    = pc4_q;
  assign bus.ifid_valid  = valid_q;
  assign bus.halted      = halt_q;
  assign bus.fetch_err   = err_q;
  assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: per-edge stimulus and
// expected IF/ID state are queued together and compared after each edge.
module tb_fetch_pc_unit;
  localparam logic [31:0] HW = 32'hFC00_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        v;
    logic        h;
    logic        e;
    logic [3:0]  cnt;
  } exp_t;

  typedef struct packed {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] mem [0:127];
  exp_t  eq[$];
  stim_t sq[$];
  int vecs = 0;
  int miss = 0;

  fetch_pc_if #(.CNT_W(4)) bus ();

  fetch_pc_unit #(.CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.instr_in = (bus.pc_out < 32'd400)
                      ? mem[bus.pc_out[8:2]] : 32'h0;

  function automatic logic [31:0] m(input int i);
    return 32'hA000_0000 | 32'(i * 4);
  endfunction

  function automatic exp_t ex(
    input logic [31:0] pc, instr, pc4,
    input logic v, h, e, input int cnt);
    ex = '{pc, instr, pc4, v, h, e, 4'(cnt)};
  endfunction

  function automatic exp_t snap();
    snap = '{bus.pc_out, bus.ifid_instr, bus.ifid_pc4,
             bus.ifid_valid, bus.halted, bus.fetch_err,
             bus.fetch_count};
  endfunction

  task automatic push(input logic st, rd,
                      input logic [31:0] rpc, input exp_t e);
    sq.push_back('{st, rd, rpc});
    eq.push_back(e);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    #1;
    rst_n = 1'b0;
    #1;
    e = ex(0, 0, 0, 0, 0, 0, 0);
    o = snap();
    vecs++;
    if (o !== e) begin
      miss++;
      $display("FAIL reset: got %h want %h", o, e);
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_named(input string name);
    int n = 0;
    while (sq.size() > 0) begin
      stim_t s;
      exp_t  e, o;
      s = sq.pop_front();
      bus.stall = s.st;
      bus.redirect = s.rd;
      bus.redirect_pc = s.rpc;
      @(posedge clk);
      #1;
      bus.stall = 1'b0;
      bus.redirect = 1'b0;
      e = eq.pop_front();
      o = snap();
      vecs++;
      if (o !== e) begin
        miss++;
        $display("FAIL %s step %0d: got pc=%h ins=%h pc4=%h v=%b h=%b e=%b c=%0d want pc=%h ins=%h pc4=%h v=%b h=%b e=%b c=%0d",
          name, n, o.pc, o.instr, o.pc4, o.v, o.h, o.e, o.cnt,
          e.pc, e.instr, e.pc4, e.v, e.h, e.e, e.cnt);
      end
      n++;
    end
  endtask

  task automatic test_sequential();
    push(0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    push(0, 0, 0, ex(4, m(0), 4, 1, 0, 0, 1));
    push(0, 0, 0, ex(8, m(1), 8, 1, 0, 0, 2));
    run_named("sequential");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++)
      push(1, 0, 0, ex(8, m(1), 8, 1, 0, 0, 2));
    push(0, 0, 0, ex(12, m(2), 12, 1, 0, 0, 3));
    run_named("stall");
  endtask

  task automatic test_redirect();
    push(1, 1, 32'h40, ex(32'h40, 0, 0, 0, 0, 0, 3));
    push(0, 0, 0, ex(32'h44, m(16), 32'h44, 1, 0, 0, 4));
    run_named("redirect");
  endtask

  task automatic test_halt_word();
    mem[4] = HW;
    push(0, 1, 32'h10, ex(32'h10, 0, 0, 0, 0, 0, 4));
    push(0, 0, 0, ex(32'h10, HW, 32'h14, 1, 1, 0, 5));
    push(1, 1, 32'h40, ex(32'h10, HW, 32'h14, 0, 1, 0, 5));
    push(0, 0, 0, ex(32'h10, HW, 32'h14, 0, 1, 0, 5));
    run_named("halt_word");
    mem[4] = m(4);
  endtask

  task automatic test_async_reset();
    exp_t e, o;
    rst_n = 1'b0;
    #1;
    e = ex(0, 0, 0, 0, 0, 0, 0);
    o = snap();
    vecs++;
    if (o !== e) begin
      miss++;
      $display("FAIL async_reset: got %h want %h", o, e);
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_end_of_mem();
    push(0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 392, ex(392, 0, 0, 0, 0, 0, 0));
    push(0, 0, 0, ex(396, m(98), 396, 1, 0, 0, 1));
    push(0, 0, 0, ex(400, m(99), 400, 1, 0, 0, 2));
    push(0, 0, 0, ex(400, m(99), 400, 0, 1, 1, 2));
    push(0, 1, 0, ex(400, m(99), 400, 0, 1, 1, 2));
    run_named("end_of_mem");
  endtask

  task automatic test_bad_redirect();
    rst_pulse();
    push(0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    push(0, 0, 0, ex(4, m(0), 4, 1, 0, 0, 1));
    push(0, 1, 32'h22, ex(4, m(0), 4, 0, 1, 1, 1));
    push(0, 0, 0, ex(4, m(0), 4, 0, 1, 1, 1));
    run_named("misaligned");
    rst_pulse();
    push(0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 400, ex(0, 0, 0, 0, 1, 1, 0));
    run_named("out_of_range");
  endtask

  task automatic test_saturation();
    rst_pulse();
    push(0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++)
      push(0, 0, 0, ex(32'(4 * (i + 1)), m(i),
        32'(4 * (i + 1)), 1, 0, 0,
        (i + 1 > 15) ? 15 : i + 1));
    run_named("saturation");
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = m(i);
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt_word();
    test_async_reset();
    test_end_of_mem();
    test_bad_redirect();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end
endmodule
